// File: rtl/video_dnn_frame_vote.sv
// Frame vote stage: the classified pixel stream passes through one register stage,
// and at each start-of-frame the block emits one beat with the previous frame's majority class.
module video_dnn_frame_vote #(
  parameter int NUM_CLASS     = 10,
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 80,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4,
  parameter int VOTE_WIDTH    = 20,
  parameter int THRESHOLD     = 4
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [TNUMBER_WIDTH-1:0] m_result_number,
  output logic [VOTE_WIDTH-1:0]    m_result_votes,
  output logic [VOTE_WIDTH+3:0]    m_result_total,
  output logic                     m_result_valid,
  input  logic                     m_result_ready,
  output logic                     m_result_drop
);
  localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int TOT_W = VOTE_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
  state_t state_q, state_d;

  logic [TUSER_WIDTH-1:0]   tuser_q;
  logic                     tlast_q, tvalid_q;
  logic [TNUMBER_WIDTH-1:0] tnumber_q;
  logic [TCOUNT_WIDTH-1:0]  tcount_q;
  logic [TDATA_WIDTH-1:0]   tdata_q;

  logic [VOTE_WIDTH-1:0]    votes_q [NUM_CLASS];
  logic [VOTE_WIDTH-1:0]    votes_d [NUM_CLASS];
  logic [VOTE_WIDTH-1:0]    snap_q  [NUM_CLASS];
  logic [TOT_W-1:0]         total_q, total_d;
  logic                     frame_active_q, drop_q, hit;
  logic [IDX_W-1:0]         idx_q;
  logic [TNUMBER_WIDTH-1:0] res_num_q;
  logic [VOTE_WIDTH-1:0]    res_votes_q;
  logic [TOT_W-1:0]         res_total_q;

  logic cke, accept, sof, conf, start;
  assign cke    = !tvalid_q | m_axi4s_tready;
  assign accept = s_axi4s_tvalid & cke;
  assign sof    = accept & s_axi4s_tuser[0];
  assign conf   = s_axi4s_tcount >= TCOUNT_WIDTH'(THRESHOLD);
  assign start  = sof & frame_active_q & (state_q == IDLE);

  assign s_axi4s_tready  = cke;
  assign m_axi4s_tuser   = tuser_q;
  assign m_axi4s_tlast   = tlast_q;
  assign m_axi4s_tnumber = tnumber_q;
  assign m_axi4s_tcount  = tcount_q;
  assign m_axi4s_tdata   = tdata_q;
  assign m_axi4s_tvalid  = tvalid_q;
  assign m_result_number = res_num_q;
  assign m_result_votes  = res_votes_q;
  assign m_result_total  = res_total_q;
  assign m_result_valid  = (state_q == OUT);
  assign m_result_drop   = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tuser_q <= '0; tlast_q <= 1'b0; tnumber_q <= '0;
      tcount_q <= '0; tdata_q <= '0; tvalid_q <= 1'b0;
    end else if (cke) begin
      tuser_q <= s_axi4s_tuser; tlast_q <= s_axi4s_tlast; tnumber_q <= s_axi4s_tnumber;
      tcount_q <= s_axi4s_tcount; tdata_q <= s_axi4s_tdata; tvalid_q <= s_axi4s_tvalid;
    end
  end

  // An SOF clears the live counters first, so its own vote lands in the new frame.
  always_comb begin
    votes_d = votes_q;
    total_d = total_q;
    hit     = 1'b0;
    if (sof) begin
      for (int c = 0; c < NUM_CLASS; c++) votes_d[c] = '0;
      total_d = '0;
    end
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (accept && conf && s_axi4s_tnumber == TNUMBER_WIDTH'(c)) begin
        hit = 1'b1;
        if (votes_d[c] != '1) votes_d[c] = votes_d[c] + VOTE_WIDTH'(1);
      end
    end
    if (hit && total_d != '1) total_d = total_d + TOT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (idx_q == IDX_W'(NUM_CLASS - 1)) state_d = OUT;
      OUT:     if (m_result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        votes_q[c] <= '0;
        snap_q[c]  <= '0;
      end
      total_q <= '0; frame_active_q <= 1'b0; drop_q <= 1'b0; idx_q <= '0;
      res_num_q <= '0; res_votes_q <= '0; res_total_q <= '0;
    end else begin
      votes_q <= votes_d;
      total_q <= total_d;
      drop_q  <= sof & frame_active_q & (state_q != IDLE);
      if (sof) frame_active_q <= 1'b1;
      if (start) begin
        snap_q      <= votes_q;
        res_total_q <= total_q;
        res_num_q   <= '0;
        res_votes_q <= '0;
        idx_q       <= '0;
      end else if (state_q == SCAN) begin
        // Strict compare keeps the lowest index on ties.
        if (snap_q[idx_q] > res_votes_q) begin
          res_votes_q <= snap_q[idx_q];
          res_num_q   <= TNUMBER_WIDTH'(idx_q);
        end
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_video_dnn_frame_vote.sv
// Bench for video_dnn_frame_vote: table frames, random back-pressure, drop and reset sequences.
module tb_video_dnn_frame_vote;
  localparam int NC = 10;
  localparam int TH = 4;
  localparam int VW = 20;

  typedef struct packed {
    logic [0:0]  user;
    logic        last;
    logic [3:0]  num;
    logic [3:0]  cnt;
    logic [79:0] data;
  } beat_t;
  typedef struct packed {
    logic [3:0]  num;
    logic [19:0] votes;
    logic [23:0] total;
  } res_t;
  typedef struct {
    int na; int ca; int ta;
    int nb; int cb; int tb;
    int e_num; int e_votes; int e_total;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  s_tuser, m_tuser;
  logic        s_tlast, m_tlast, s_tvalid, s_tready, m_tvalid, m_tready;
  logic [3:0]  s_tnumber, m_tnumber, s_tcount, m_tcount;
  logic [79:0] s_tdata, m_tdata;
  logic [3:0]  r_number;
  logic [19:0] r_votes;
  logic [23:0] r_total;
  logic        r_valid, rrdy, r_drop;

  video_dnn_frame_vote dut (
    .reset(reset), .clk(clk),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tnumber(s_tnumber),
    .s_axi4s_tcount(s_tcount), .s_axi4s_tdata(s_tdata), .s_axi4s_tvalid(s_tvalid),
    .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
    .m_axi4s_tcount(m_tcount), .m_axi4s_tdata(m_tdata), .m_axi4s_tvalid(m_tvalid),
    .m_axi4s_tready(m_tready),
    .m_result_number(r_number), .m_result_votes(r_votes), .m_result_total(r_total),
    .m_result_valid(r_valid), .m_result_ready(rrdy), .m_result_drop(r_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0, drop_cnt = 0, sof_cyc = 0;
  bit rand_rdy = 0, prev_rv = 0;

  // Reference model: per-class vote tallies of the open frame.
  int   mv [NC];
  int   mtot = 0;
  bit   mactive = 0, close_tbl = 0, next_tbl = 0;
  res_t close_exp, next_exp;
  res_t exp_q[$];
  beat_t in_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic res_t model_res();
    res_t r;
    int bi = 0;
    for (int c = 1; c < NC; c++) if (mv[c] > mv[bi]) bi = c;
    r.num = 4'(bi); r.votes = 20'(mv[bi]); r.total = 24'(mtot);
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) mv[c] = 0;
    mtot = 0;
  endtask

  task automatic model_beat(input beat_t b);
    if (b.user[0]) begin
      if (mactive) exp_q.push_back(close_tbl ? close_exp : model_res());
      model_clear();
      mactive = 1; close_tbl = next_tbl; close_exp = next_exp; sof_cyc = cyc;
    end
    if (b.cnt >= TH && int'(b.num) < NC) begin
      if (mv[b.num] < 2**VW - 1) mv[b.num]++;
      if (mtot < 2**(VW+4) - 1) mtot++;
    end
  endtask

  function automatic beat_t mk(input int u, input int l, input int n, input int c);
    beat_t b;
    b.user = 1'(u); b.last = 1'(l); b.num = 4'(n); b.cnt = 4'(c);
    b.data = {16'($urandom), $urandom, $urandom};
    return b;
  endfunction

  task automatic send_beat(input beat_t b);
    bit acc = 0;
    int t = 0;
    s_tuser = b.user; s_tlast = b.last; s_tnumber = b.num; s_tcount = b.cnt;
    s_tdata = b.data; s_tvalid = 1'b1;
    while (!acc && t < 500) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; t++;
    end
    s_tvalid = 1'b0;
    if (acc) begin
      in_q.push_back(b);
      model_beat(b);
    end else begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic send_tbl_frame(input frame_t f);
    int n = f.na + f.nb;
    next_tbl = 1;
    next_exp.num = 4'(f.e_num); next_exp.votes = 20'(f.e_votes); next_exp.total = 24'(f.e_total);
    for (int i = 0; i < n; i++) begin
      if (i < f.na) send_beat(mk(i == 0 ? 1 : 0, i == n-1 ? 1 : 0, f.ca, f.ta));
      else          send_beat(mk(0, i == n-1 ? 1 : 0, f.cb, f.tb));
    end
  endtask

  task automatic send_rand_frame(input int n);
    next_tbl = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_beat(mk(i == 0 ? 1 : 0, i == n-1 ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 15)));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL result_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output scoreboards: pass-through order, result contents, result latency, drop pulses.
  always @(negedge clk) begin
    beat_t got;
    res_t  e;
    if (reset) prev_rv = 0;
    else begin
      if (m_tvalid && m_tready) begin
        got = {m_tuser, m_tlast, m_tnumber, m_tcount, m_tdata};
        if (in_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL passthru_extra actual=%0h required=none", got);
        end else chk("passthru_beat", got, in_q.pop_front());
      end
      if (r_valid && !prev_rv) chk("result_latency", cyc - sof_cyc, 10);
      prev_rv = r_valid;
      if (r_valid && rrdy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL result_unexpected actual=%0d required=none", r_number);
        end else begin
          e = exp_q.pop_front();
          chk("result_number", r_number, e.num);
          chk("result_votes", r_votes, e.votes);
          chk("result_total", r_total, e.total);
        end
      end
      if (r_drop) drop_cnt++;
    end
  end

  frame_t tbl [6];

  initial begin
    reset = 1'b1; rrdy = 1'b1;
    s_tvalid = 0; s_tuser = 0; s_tlast = 0; s_tnumber = 0; s_tcount = 0; s_tdata = 0;
    model_clear();
    tbl[0] = '{60, 3, 8, 40, 7, 5, 3, 60, 100};
    tbl[1] = '{20, 2, 9, 20, 5, 4, 2, 20, 40};
    tbl[2] = '{50, 1, 3, 5, 4, 4, 4, 5, 5};
    tbl[3] = '{12, 12, 15, 3, 0, 0, 0, 0, 0};
    tbl[4] = '{7, 9, 15, 7, 8, 4, 8, 7, 14};
    tbl[5] = '{30, 6, 4, 1, 15, 15, 6, 30, 30};

    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_result_valid", r_valid, 0);
    chk("rst_result_drop", r_drop, 0);
    chk("rst_result_fields", {r_number, r_votes, r_total}, 0);
    chk("rst_m_data", {m_tuser, m_tlast, m_tnumber, m_tcount, m_tdata}, 0);
    chk("rst_s_tready", s_tready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) send_tbl_frame(tbl[i]);

    rand_rdy = 1;
    for (int f = 0; f < 8; f++) send_rand_frame($urandom_range(15, 40));
    rand_rdy = 0;
    wait_drain();

    // Result held across two boundaries: second one is dropped.
    rrdy = 1'b0;
    send_rand_frame(20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_valid", r_valid, 1);
      if (exp_q.size() > 0)
        chk("held_fields", {r_number, r_votes, r_total},
            {exp_q[0].num, exp_q[0].votes, exp_q[0].total});
    end
    @(posedge clk); #1;
    send_rand_frame(20);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    rrdy = 1'b1;
    wait_drain();
    send_rand_frame(15);
    wait_drain();

    // Reset during SCAN loses the pending result and re-arms the first-SOF rule.
    send_beat(mk(1, 0, 3, 9));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_scan_result_valid", r_valid, 0);
    chk("rst_scan_result_total", r_total, 0);
    exp_q.delete(); in_q.delete(); model_clear(); mactive = 0; close_tbl = 0;
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    send_rand_frame(15);
    repeat (20) @(negedge clk);
    chk("no_result_after_reset", r_valid, 0);
    @(posedge clk); #1;
    send_rand_frame(15);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("drop_pulses", drop_cnt, 1);
    chk("passthru_drained", in_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_dnn_frame_vote.md
# video_dnn_frame_vote

Per-frame class voting stage placed directly after the per-pixel max-count classifier in the MNIST video DNN path. It passes the classified pixel stream through unchanged with one register stage. Each confident pixel casts a vote for its winning class, and at every frame boundary the block emits one result beat carrying the frame's majority class. The result stream feeds the overlay and register readout logic.

## Interface
- NUM_CLASS, 10, number of classes
- TUSER_WIDTH, 1, video tuser width; bit 0 is start-of-frame (SOF)
- TDATA_WIDTH, 80, pass-through payload width
- TNUMBER_WIDTH, 4, class index width
- TCOUNT_WIDTH, 4, per-pixel max count width
- VOTE_WIDTH, 20, per-class vote accumulator width
- THRESHOLD, 4, minimum tcount for a pixel to vote
- reset  in  1  asynchronous, active-high reset
- clk  in  1  single clock; all logic is synchronous to it
- s_axi4s_tuser / tlast / tnumber / tcount / tdata  in  TUSER_WIDTH / 1 / TNUMBER_WIDTH / TCOUNT_WIDTH / TDATA_WIDTH  classified pixel stream
- s_axi4s_tvalid  in  1;  s_axi4s_tready  out  1
- m_axi4s_tuser / tlast / tnumber / tcount / tdata  out  same widths  registered pass-through
- m_axi4s_tvalid  out  1;  m_axi4s_tready  in  1
- m_result_number  out  TNUMBER_WIDTH  winning class of the completed frame
- m_result_votes  out  VOTE_WIDTH  vote count of the winning class
- m_result_total  out  VOTE_WIDTH+4  sum of all votes in the frame
- m_result_valid  out  1;  m_result_ready  in  1
- m_result_drop  out  1  one-cycle pulse when a frame result is discarded

## Operation
- Pass-through:
  - cke = !m_axi4s_tvalid | m_axi4s_tready; s_axi4s_tready = cke.
  - A beat is accepted when s_axi4s_tvalid & cke.
  - On cke, all m_axi4s_* outputs load from s_axi4s_*; m_axi4s_tvalid loads s_axi4s_tvalid.
- Voting on each accepted beat:
  - The beat votes if tcount >= THRESHOLD and tnumber < NUM_CLASS.
  - votes[tnumber] increments and saturates at all-ones; total increments and saturates.
  - A tnumber >= NUM_CLASS never votes.
- Frame boundary: an accepted beat with tuser[0]=1.
  - If frame_active=1 and the FSM is IDLE: copy votes and total into the snapshot bank, clear the live counters, and start SCAN.
  - If frame_active=1 and the FSM is not IDLE: discard the frame, clear the live counters, and pulse m_result_drop.
  - If frame_active=0 (first SOF after reset): set frame_active=1; no result.
  - The SOF beat's own vote goes to the new frame, i.e. the cleared counters plus that vote.
- FSM states:
  - IDLE: wait for a frame boundary.
  - SCAN: idx runs 0..NUM_CLASS-1, one class per cycle. best updates only when snap[idx] > best_votes (strict), so ties go to the lowest index. When idx = NUM_CLASS-1 the FSM moves to OUT.
  - OUT: m_result_valid=1 with stable outputs until m_result_ready=1, then return to IDLE.
- An all-zero frame yields number=0, votes=0, total=0, and the result is still emitted.
- Widths:
  - The comparison is unsigned over VOTE_WIDTH.
  - total saturates at 2^(VOTE_WIDTH+4)-1.

## Timing
- Reset values (asynchronous assert):
  - m_axi4s_tvalid=0, m_result_valid=0, m_result_drop=0.
  - m_result_number/votes/total=0; m_axi4s data outputs=0.
  - FSM=IDLE, frame_active=0, all counters 0.
- Pass-through latency is 1 cycle. A stall (m_axi4s_tready=0 with m_axi4s_tvalid=1) holds every output and blocks acceptance, so no vote is counted during a stall.
- Result timing: SOF accepted at edge E0 → m_result_valid is high after edge E0+NUM_CLASS (NUM_CLASS cycles of SCAN).
- The result handshake completes on the edge where m_result_valid & m_result_ready; m_result_valid falls after that edge.
- The pass-through never stalls because of result back-pressure; results are dropped instead.
- A reset asserted mid-frame or mid-SCAN/OUT loses the pending result. No drop pulse is issued.

## Test plan
- Frame of 100 pixels, then an SOF; 60 pixels with tnumber=3/tcount=8, 40 with tnumber=7/tcount=5 → number=3, votes=60, total=100, valid 10 cycles after the SOF edge.
- Tie: 20 votes for class 2 and 20 for class 5 → number=2, votes=20.
- Threshold: 50 pixels with tnumber=1/tcount=3 and 5 with tnumber=4/tcount=4 → number=4, votes=5, total=5. Also tnumber=12/tcount=15 → not counted.
- Back-pressure: random m_axi4s_tready at 50% → output beats are bit-identical to the input order, with no duplicates or losses, and votes count only accepted beats.
- m_result_ready held 0 across two frame boundaries → first result held, second frame gives m_result_drop=1 for one cycle, third frame's result is correct after release.
- First SOF after reset gives no result. Reset asserted during SCAN → m_result_valid=0 immediately and the next SOF gives no result.
